// File: rtl/wb_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_stage
// Purpose  : Write-back pipeline register with register file and retire
//            counter. The W register captures the instruction leaving the
//            memory stage. A committing instruction writes its results into
//            the register file on the same edge. Read ports see the value
//            being written this cycle, with valM taking priority over valE.
//            An error or halt status sets a sticky halted flag, which blocks
//            all further writes and retire counts until reset.
// Ports    : clk_i, rst_n_i (async, active-low)
//            stall_i / bubble_i          - W register control (stall wins)
//            stat_i, icode_i, valE_i, valM_i, dstE_i, dstM_i - from M stage
//            rd_addr_i / rd_data_o       - NREAD packed read ports
//            stat_o, icode_o, valE_o, valM_o - W register contents
//            halted_o                    - sticky halt/exception flag
//            retired_o                   - saturating retire counter
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile_stage #(
    parameter int DATA_W   = 64,
    parameter int REG_ID_W = 4,
    parameter int NREAD    = 2,
    parameter int CNT_W    = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       stall_i,
    input  logic                       bubble_i,
    input  logic [2:0]                 stat_i,
    input  logic [3:0]                 icode_i,
    input  logic [DATA_W-1:0]          valE_i,
    input  logic [DATA_W-1:0]          valM_i,
    input  logic [REG_ID_W-1:0]        dstE_i,
    input  logic [REG_ID_W-1:0]        dstM_i,
    input  logic [NREAD*REG_ID_W-1:0]  rd_addr_i,
    output logic [NREAD*DATA_W-1:0]    rd_data_o,
    output logic [2:0]                 stat_o,
    output logic [3:0]                 icode_o,
    output logic [DATA_W-1:0]          valE_o,
    output logic [DATA_W-1:0]          valM_o,
    output logic                       halted_o,
    output logic [CNT_W-1:0]           retired_o
);

    localparam logic [REG_ID_W-1:0] c_RNONE = '1;
    localparam int                  c_NREG  = (1 << REG_ID_W) - 1;

    localparam logic [2:0] c_STAT_RESET  = 3'd0;
    localparam logic [2:0] c_STAT_OK     = 3'd1;
    localparam logic [2:0] c_STAT_HLT    = 3'd2;
    localparam logic [2:0] c_STAT_ADR    = 3'd3;
    localparam logic [2:0] c_STAT_INS    = 3'd4;
    localparam logic [2:0] c_STAT_BUBBLE = 3'd5;

    localparam logic [3:0]       c_ICODE_NOP = 4'd1;
    localparam logic [CNT_W-1:0] c_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]          r_stat;
    logic [3:0]          r_icode;
    logic [DATA_W-1:0]   r_valE;
    logic [DATA_W-1:0]   r_valM;
    logic [REG_ID_W-1:0] r_dstE;
    logic [REG_ID_W-1:0] r_dstM;
    logic                r_halted;
    logic [CNT_W-1:0]    r_retired;
    logic [DATA_W-1:0]   r_regs [0:c_NREG-1];

    logic w_commit;
    logic w_fault;

    // Only a valid instruction retires, and only while the pipeline moves
    // and the machine has not already stopped.
    assign w_commit = (r_stat == c_STAT_OK) && !stall_i && !r_halted;
    assign w_fault  = (r_stat == c_STAT_HLT) || (r_stat == c_STAT_ADR) ||
                      (r_stat == c_STAT_INS);

    // W pipeline register; stall has priority over bubble.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stat  <= c_STAT_RESET;
            r_icode <= 4'd0;
            r_valE  <= '0;
            r_valM  <= '0;
            r_dstE  <= c_RNONE;
            r_dstM  <= c_RNONE;
        end else if (stall_i) begin
            r_stat  <= r_stat;
        end else if (bubble_i) begin
            r_stat  <= c_STAT_BUBBLE;
            r_icode <= c_ICODE_NOP;
            r_valE  <= '0;
            r_valM  <= '0;
            r_dstE  <= c_RNONE;
            r_dstM  <= c_RNONE;
        end else begin
            r_stat  <= stat_i;
            r_icode <= icode_i;
            r_valE  <= valE_i;
            r_valM  <= valM_i;
            r_dstE  <= dstE_i;
            r_dstM  <= dstM_i;
        end
    end

    // Register file write. The valM assignment comes last, so it wins
    // when both destinations name the same register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            if (r_dstE != c_RNONE) begin
                r_regs[r_dstE] <= r_valE;
            end
            if (r_dstM != c_RNONE) begin
                r_regs[r_dstM] <= r_valM;
            end
        end
    end

    // Sticky halt flag and saturating retire counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_halted  <= 1'b0;
            r_retired <= '0;
        end else begin
            if (!stall_i && w_fault) begin
                r_halted <= 1'b1;
            end
            if (w_commit && (r_retired != {CNT_W{1'b1}})) begin
                r_retired <= r_retired + c_CNT_ONE;
            end
        end
    end

    // Combinational read ports that bypass the value being written this cycle.
    generate
        for (genvar k = 0; k < NREAD; k++) begin : g_rd
            logic [REG_ID_W-1:0] w_addr;
            logic [DATA_W-1:0]   w_data;

            assign w_addr = rd_addr_i[k*REG_ID_W +: REG_ID_W];

            always_comb begin
                w_data = '0;
                if (w_addr == c_RNONE) begin
                    w_data = '0;
                end else if (w_commit && (w_addr == r_dstM)) begin
                    w_data = r_valM;
                end else if (w_commit && (w_addr == r_dstE)) begin
                    w_data = r_valE;
                end else begin
                    w_data = r_regs[w_addr];
                end
            end

            assign rd_data_o[k*DATA_W +: DATA_W] = w_data;
        end
    endgenerate

    assign stat_o    = r_stat;
    assign icode_o   = r_icode;
    assign valE_o    = r_valE;
    assign valM_o    = r_valM;
    assign halted_o  = r_halted;
    assign retired_o = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile_stage
// Purpose  : Self-checking bench for wb_regfile_stage. Directed scenarios
//            plus randomized traffic compared against a behavioural model.
//            A second instance with a 2-bit counter covers saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_stage;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         stall_i;
    logic         bubble_i;
    logic [2:0]   stat_i;
    logic [3:0]   icode_i;
    logic [63:0]  valE_i;
    logic [63:0]  valM_i;
    logic [3:0]   dstE_i;
    logic [3:0]   dstM_i;
    logic [7:0]   rd_addr_i;
    logic [127:0] rd_data_o;
    logic [2:0]   stat_o;
    logic [3:0]   icode_o;
    logic [63:0]  valE_o;
    logic [63:0]  valM_o;
    logic         halted_o;
    logic [31:0]  retired_o;

    logic [127:0] rd_data_s;
    logic [2:0]   stat_s;
    logic [3:0]   icode_s;
    logic [63:0]  valE_s;
    logic [63:0]  valM_s;
    logic         halted_s;
    logic [1:0]   retired_s;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    wb_regfile_stage #(.DATA_W(64), .REG_ID_W(4), .NREAD(2), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .bubble_i(bubble_i),
        .stat_i(stat_i), .icode_i(icode_i), .valE_i(valE_i), .valM_i(valM_i),
        .dstE_i(dstE_i), .dstM_i(dstM_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
        .stat_o(stat_o), .icode_o(icode_o), .valE_o(valE_o), .valM_o(valM_o),
        .halted_o(halted_o), .retired_o(retired_o)
    );

    wb_regfile_stage #(.DATA_W(64), .REG_ID_W(4), .NREAD(2), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .stall_i(stall_i), .bubble_i(bubble_i),
        .stat_i(stat_i), .icode_i(icode_i), .valE_i(valE_i), .valM_i(valM_i),
        .dstE_i(dstE_i), .dstM_i(dstM_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_s),
        .stat_o(stat_s), .icode_o(icode_s), .valE_o(valE_s), .valM_o(valM_s),
        .halted_o(halted_s), .retired_o(retired_s)
    );

    // ---------------- behavioural reference model ----------------
    logic [63:0] m_regs [0:14];
    logic [2:0]  m_stat;
    logic [3:0]  m_icode;
    logic [63:0] m_valE;
    logic [63:0] m_valM;
    logic [3:0]  m_dstE;
    logic [3:0]  m_dstM;
    logic        m_halted;
    int          m_ret;

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
        m_stat = 3'd0; m_icode = 4'd0; m_valE = 64'd0; m_valM = 64'd0;
        m_dstE = 4'hF; m_dstM = 4'hF; m_halted = 1'b0; m_ret = 0;
    endtask

    function automatic logic model_commits();
        return (m_stat == 3'd1) && !stall_i && !m_halted;
    endfunction

    function automatic logic [63:0] model_read(input logic [3:0] a);
        if (a == 4'hF) return 64'd0;
        if (model_commits() && a == m_dstM) return m_valM;
        if (model_commits() && a == m_dstE) return m_valE;
        return m_regs[a];
    endfunction

    // Advance the model by one rising edge using the inputs currently applied,
    // then let the DUT take the same edge.
    task automatic clk_edge();
        if (model_commits()) begin
            if (m_dstE != 4'hF) m_regs[m_dstE] = m_valE;
            if (m_dstM != 4'hF) m_regs[m_dstM] = m_valM;
            m_ret++;
        end
        if (!stall_i && (m_stat == 3'd2 || m_stat == 3'd3 || m_stat == 3'd4))
            m_halted = 1'b1;
        if (!stall_i) begin
            if (bubble_i) begin
                m_stat = 3'd5; m_icode = 4'd1; m_valE = 64'd0; m_valM = 64'd0;
                m_dstE = 4'hF; m_dstM = 4'hF;
            end else begin
                m_stat = stat_i; m_icode = icode_i; m_valE = valE_i; m_valM = valM_i;
                m_dstE = dstE_i; m_dstM = dstM_i;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [2:0] st, input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
        stall_i = 1'b0; bubble_i = 1'b0;
        stat_i = st; icode_i = 4'd6; valE_i = ve; valM_i = vm; dstE_i = de; dstM_i = dm;
    endtask

    task automatic do_reset();
        drive(3'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        rd_addr_i = 8'hFF;
        rst_n_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        rd_addr_i = {4'd7, 4'd0};
        #2;
        checks++; if (stat_o !== 3'd0) begin errors++; $display("FAIL reset_stat got=%0d want=0", stat_o); end
        checks++; if (icode_o !== 4'd0) begin errors++; $display("FAIL reset_icode got=%0d want=0", icode_o); end
        checks++; if (valE_o !== 64'd0 || valM_o !== 64'd0) begin errors++; $display("FAIL reset_vals got=%h/%h want=0", valE_o, valM_o); end
        checks++; if (halted_o !== 1'b0 || retired_o !== 32'd0) begin errors++; $display("FAIL reset_halt_ret got=%b/%0d want=0/0", halted_o, retired_o); end
        checks++; if (rd_data_o !== 128'd0) begin errors++; $display("FAIL reset_regs got=%h want=0", rd_data_o); end
    endtask

    task automatic test_bubble_commit();
        do_reset();
        drive(3'd1, 64'h11, 64'h0, 4'd3, 4'hF);
        clk_edge();
        bubble_i = 1'b1;
        clk_edge();
        rd_addr_i = {4'hF, 4'd3};
        #2;
        checks++; if (rd_data_o[63:0] !== 64'h11) begin errors++; $display("FAIL commit_reg3 got=%h want=11", rd_data_o[63:0]); end
        checks++; if (retired_o !== 32'd1) begin errors++; $display("FAIL commit_ret got=%0d want=1", retired_o); end
        clk_edge();
        checks++; if (retired_o !== 32'd1 || stat_o !== 3'd5) begin errors++; $display("FAIL bubble_nocount got=%0d/%0d want=1/5", retired_o, stat_o); end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(3'd1, 64'hAA, 64'hBB, 4'd5, 4'd5);
        clk_edge();
        bubble_i = 1'b1;
        rd_addr_i = {4'd5, 4'd5};
        #2;
        checks++; if (rd_data_o[63:0] !== 64'hBB) begin errors++; $display("FAIL bypass_pre got=%h want=bb", rd_data_o[63:0]); end
        clk_edge();
        #1;
        checks++; if (rd_data_o[127:64] !== 64'hBB) begin errors++; $display("FAIL bypass_post got=%h want=bb", rd_data_o[127:64]); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(3'd1, 64'h22, 64'h0, 4'd2, 4'hF);
        clk_edge();
        stall_i = 1'b1;
        bubble_i = 1'b1;
        rd_addr_i = {4'hF, 4'd2};
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (rd_data_o[63:0] !== 64'd0 || retired_o !== 32'd0) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%h/%0d want=0/0", c, rd_data_o[63:0], retired_o);
            end
            clk_edge();
        end
        stall_i = 1'b0;
        clk_edge();
        #1;
        checks++; if (rd_data_o[63:0] !== 64'h22 || retired_o !== 32'd1) begin
            errors++; $display("FAIL stall_release got=%h/%0d want=22/1", rd_data_o[63:0], retired_o);
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(3'd2, 64'h0, 64'h0, 4'hF, 4'hF);
        clk_edge();
        drive(3'd1, 64'h33, 64'h0, 4'd1, 4'hF);
        clk_edge();
        checks++; if (halted_o !== 1'b1) begin errors++; $display("FAIL halt_set got=%b want=1", halted_o); end
        bubble_i = 1'b1;
        rd_addr_i = {4'hF, 4'd1};
        #1;
        checks++; if (rd_data_o[63:0] !== 64'd0) begin errors++; $display("FAIL halt_nobypass got=%h want=0", rd_data_o[63:0]); end
        clk_edge();
        drive(3'd1, 64'h44, 64'h0, 4'd1, 4'hF);
        clk_edge();
        clk_edge();
        rd_addr_i = {4'hF, 4'd1};
        stall_i = 1'b1;
        #1;
        checks++; if (rd_data_o[63:0] !== 64'd0 || retired_o !== 32'd0 || halted_o !== 1'b1) begin
            errors++; $display("FAIL halt_frozen got=%h/%0d/%b want=0/0/1", rd_data_o[63:0], retired_o, halted_o);
        end
    endtask

    task automatic test_rnone_saturate();
        do_reset();
        drive(3'd1, 64'h55, 64'h66, 4'hF, 4'hF);
        for (int c = 0; c < 6; c++) clk_edge();
        rd_addr_i = {4'hF, 4'hF};
        #1;
        checks++; if (rd_data_o !== 128'd0) begin errors++; $display("FAIL rnone_read got=%h want=0", rd_data_o); end
        checks++; if (retired_s !== 2'd3) begin errors++; $display("FAIL sat_cnt got=%0d want=3", retired_s); end
        checks++; if (retired_o !== 32'd5) begin errors++; $display("FAIL wide_cnt got=%0d want=5", retired_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(3'd1, 64'h44, 64'h0, 4'd4, 4'hF);
        clk_edge();
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++; if (stat_o !== 3'd0 || valE_o !== 64'd0 || retired_o !== 32'd0) begin
            errors++; $display("FAIL async_rst got=%0d/%h/%0d want=0/0/0", stat_o, valE_o, retired_o);
        end
        model_reset();
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        rd_addr_i = {4'hF, 4'd4};
        #1;
        checks++; if (rd_data_o[63:0] !== 64'd0) begin errors++; $display("FAIL async_rst_reg got=%h want=0", rd_data_o[63:0]); end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c % 60 == 59) do_reset();
            r = $urandom_range(0, 99);
            if (r < 72)      stat_i = 3'd1;
            else if (r < 82) stat_i = 3'd5;
            else if (r < 88) stat_i = 3'd0;
            else if (r < 90) stat_i = 3'd2;
            else if (r < 92) stat_i = 3'd3;
            else if (r < 94) stat_i = 3'd4;
            else             stat_i = 3'd1;
            icode_i  = 4'($urandom_range(0, 15));
            valE_i   = {$urandom, $urandom};
            valM_i   = {$urandom, $urandom};
            dstE_i   = 4'($urandom_range(0, 15));
            dstM_i   = ($urandom_range(0, 3) == 0) ? dstE_i : 4'($urandom_range(0, 15));
            stall_i  = ($urandom_range(0, 99) < 15);
            bubble_i = ($urandom_range(0, 99) < 10);
            rd_addr_i = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            #2;
            checks++; if (rd_data_o[63:0] !== model_read(rd_addr_i[3:0])) begin
                errors++; $display("FAIL rnd_rd0 cyc=%0d addr=%0d got=%h want=%h", c, rd_addr_i[3:0], rd_data_o[63:0], model_read(rd_addr_i[3:0]));
            end
            checks++; if (rd_data_o[127:64] !== model_read(rd_addr_i[7:4])) begin
                errors++; $display("FAIL rnd_rd1 cyc=%0d addr=%0d got=%h want=%h", c, rd_addr_i[7:4], rd_data_o[127:64], model_read(rd_addr_i[7:4]));
            end
            clk_edge();
            checks++; if (stat_o !== m_stat || icode_o !== m_icode || valE_o !== m_valE || valM_o !== m_valM) begin
                errors++; $display("FAIL rnd_wreg cyc=%0d got=%0d/%0d/%h/%h want=%0d/%0d/%h/%h", c,
                                   stat_o, icode_o, valE_o, valM_o, m_stat, m_icode, m_valE, m_valM);
            end
            checks++; if (halted_o !== m_halted || retired_o !== 32'(m_ret)) begin
                errors++; $display("FAIL rnd_state cyc=%0d got=%b/%0d want=%b/%0d", c, halted_o, retired_o, m_halted, m_ret);
            end
            checks++; if (retired_s !== ((m_ret > 3) ? 2'd3 : 2'(m_ret))) begin
                errors++; $display("FAIL rnd_sat cyc=%0d got=%0d want_from=%0d", c, retired_s, m_ret);
            end
        end
    endtask

    initial begin
        rst_n_i   = 1'b0;
        rd_addr_i = 8'hFF;
        drive(3'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        #7;
        test_reset();
        test_bubble_commit();
        test_bypass();
        test_stall();
        test_halt();
        test_rnone_saturate();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
